// File: rtl/oc_bc_csr_target.sv
// Byte-channel endpoint: decodes framed 8-bit requests into one 32-bit CSR access
// and returns a framed status (+ read data) response. All outputs are registered.
module oc_bc_csr_target #(
  parameter int ClockHz       = 100_000_000,
  parameter int TimeoutCycles = ClockHz / 1000,
  parameter int AddressBits   = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             bcInData,
  input  logic                   bcInValid,
  output logic                   bcInReady,
  output logic [7:0]             bcOutData,
  output logic                   bcOutValid,
  input  logic                   bcOutReady,
  output logic [AddressBits-1:0] csrAddress,
  output logic [31:0]            csrWData,
  output logic                   csrWrite,
  output logic                   csrRead,
  input  logic [31:0]            csrRData,
  input  logic                   csrReady,
  input  logic                   csrError
);

  localparam int TmoW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [TmoW-1:0] TmoLast = (TimeoutCycles > 0) ? TmoW'(TimeoutCycles - 1) : '0;
  localparam logic [TmoW-1:0] TmoMax  = '1;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_CSR, S_RESP} state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_in_rdy, r_out_vld, r_is_wr, r_csr_wr, r_csr_rd;
  logic [7:0]             r_out_dat;
  logic [1:0]             r_cnt;
  logic [2:0]             r_left;
  logic [AddressBits-1:0] r_addr;
  logic [31:0]            r_wdata, r_rdata;
  logic [TmoW-1:0]        r_tmo_cnt;
  logic                   w_in_fire, w_out_fire, w_tmo_hit, w_op_ok;

  assign w_in_fire  = bcInValid && r_in_rdy;
  assign w_out_fire = r_out_vld && bcOutReady;
  assign w_tmo_hit  = (TimeoutCycles != 0) && (r_tmo_cnt == TmoLast);
  assign w_op_ok    = (bcInData == 8'h01) || (bcInData == 8'h02);

  assign bcInReady  = r_in_rdy;
  assign bcOutData  = r_out_dat;
  assign bcOutValid = r_out_vld;
  assign csrAddress = r_addr;
  assign csrWData   = r_wdata;
  assign csrWrite   = r_csr_wr;
  assign csrRead    = r_csr_rd;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_in_fire && w_op_ok)                 w_state_nxt = S_ADDR;
        else if (w_in_fire && bcInData != 8'h00)  w_state_nxt = S_RESP;
      end
      S_ADDR:  if (w_in_fire && r_cnt == 2'd3) w_state_nxt = r_is_wr ? S_WDATA : S_CSR;
      S_WDATA: if (w_in_fire && r_cnt == 2'd3) w_state_nxt = S_CSR;
      S_CSR:   if (csrReady || w_tmo_hit)      w_state_nxt = S_RESP;
      S_RESP:  if (w_out_fire && r_left == 3'd0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_in_rdy  <= 1'b0;
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
      r_is_wr   <= 1'b0;
      r_csr_wr  <= 1'b0;
      r_csr_rd  <= 1'b0;
      r_cnt     <= '0;
      r_left    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_tmo_cnt <= '0;
    end else begin
      r_in_rdy <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_ADDR) || (w_state_nxt == S_WDATA);
      case (r_state)
        S_IDLE: if (w_in_fire) begin
          r_cnt   <= '0;
          r_is_wr <= (bcInData == 8'h01);
          if (!w_op_ok && bcInData != 8'h00) begin
            r_out_vld <= 1'b1;
            r_out_dat <= 8'h03;
            r_left    <= '0;
          end
        end
        S_ADDR: if (w_in_fire) begin
          // Upper address bytes beyond AddressBits fall off the top of the shift.
          r_addr <= AddressBits'({r_addr, bcInData});
          r_cnt  <= r_cnt + 2'd1;
          if (r_cnt == 2'd3 && !r_is_wr) begin
            r_csr_rd  <= 1'b1;
            r_tmo_cnt <= '0;
          end
        end
        S_WDATA: if (w_in_fire) begin
          r_wdata <= {r_wdata[23:0], bcInData};
          r_cnt   <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_csr_wr  <= 1'b1;
            r_tmo_cnt <= '0;
          end
        end
        S_CSR: begin
          if (csrReady) begin
            r_csr_wr  <= 1'b0;
            r_csr_rd  <= 1'b0;
            r_out_vld <= 1'b1;
            r_out_dat <= csrError ? 8'h01 : 8'h00;
            r_rdata   <= csrRData;
            r_left    <= (!csrError && !r_is_wr) ? 3'd4 : 3'd0;
          end else if (w_tmo_hit) begin
            r_csr_wr  <= 1'b0;
            r_csr_rd  <= 1'b0;
            r_out_vld <= 1'b1;
            r_out_dat <= 8'h02;
            r_left    <= '0;
          end else if (r_tmo_cnt != TmoMax) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_RESP: if (w_out_fire) begin
          if (r_left == 3'd0) begin
            r_out_vld <= 1'b0;
          end else begin
            r_out_dat <= r_rdata[31:24];
            r_rdata   <= {r_rdata[23:0], 8'h00};
            r_left    <= r_left - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
